fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction fetch stage of the 16-bit multicycle datapath; sits directly upstream of the IR/PC load stage.
//  Owns the PC, issues req/ack reads to instruction memory and registers the returned word.
//  Drives inst, pcplus, IRwrite and pcwrite to the IR/PC load stage; accepts PC redirects (branch/jump) from control.
// PARAMETERS
//  PC_W      16       PC and instruction-memory address width
//  INST_W    16       instruction width
//  RESET_PC  16'h0000 PC value after reset
//  PC_INC    1        PC increment per instruction (word addressed)
// PORTS
//  clk            in   1       clock; all state changes on posedge
//  rst            in   1       synchronous, active-high reset
//  fetch_en       in   1       control requests one instruction fetch
//  redirect_valid in   1       control requests PC load (branch/jump taken)
//  redirect_pc    in   PC_W    redirect target
//  imem_req       out  1       read request to instruction memory
//  imem_addr      out  PC_W    read address (= pc)
//  imem_rdata     in   INST_W  read data, valid when imem_ack=1
//  imem_ack       in   1       read complete
//  pc             out  PC_W    current PC register
//  pcplus         out  PC_W    pc + PC_INC, combinational, mod 2^PC_W
//  inst           out  INST_W  registered fetched instruction
//  IRwrite        out  1       1-cycle pulse: inst valid, load IR
//  pcwrite        out  1       1-cycle pulse: pcplus valid, load PC
//  busy           out  1       1 whenever state != IDLE
// BEHAVIOUR
//  Reset (sync): state=IDLE, pc=RESET_PC, inst=0, imem_req=0, IRwrite=0, pcwrite=0, pending redirect cleared.
//  States: IDLE -> REQ -> LOAD -> IDLE.
//  IDLE: imem_req=0. If redirect_valid (or redirect pending): pc<=redirect_pc/pending value, pending cleared.
//    If fetch_en: -> REQ. Redirect and fetch_en same cycle: redirect applied first, fetch uses new PC.
//    fetch_en with pending redirect: pending value used; a live redirect_valid same cycle overrides it.
//  REQ: imem_req=1, imem_addr=pc, both held stable until imem_ack. On imem_ack: inst<=imem_rdata, -> LOAD.
//  LOAD: IRwrite=1, pcwrite=1 for exactly one cycle; pcplus=pc+PC_INC; at clock edge pc<=pcplus, -> IDLE.
//  Latency: fetch_en sampled in cycle T; REQ from T+1; ack in cycle A>=T+1; LOAD in A+1; IDLE in A+2.
//    Zero-wait memory (ack in T+1): IRwrite at T+2; back-to-back fetch every 3 cycles.
//  Redirect while busy (REQ/LOAD): stored in 1-entry pending buffer; later redirect overwrites earlier;
//    in-flight fetch completes normally (pc still advances to pcplus), then pending loads pc on IDLE.
//  fetch_en while busy: ignored (not queued); control must wait for busy=0.
//  imem_ack outside REQ: ignored, inst unchanged. imem_rdata sampled only on ack in REQ.
//  Wrap: pc=16'hFFFF, PC_INC=1 -> pcplus=16'h0000, pc wraps to 0 after LOAD.
//  rst in any state (incl. mid-REQ): imem_req drops next cycle, returned ack/data discarded, reset values above.
//  IRwrite/pcwrite never asserted outside LOAD; never asserted during or in cycle after rst.
// TESTING
//  1 Reset: rst=1 two cycles -> pc=0000, inst=0000, imem_req=0, busy=0, IRwrite=pcwrite=0.
//  2 Zero-wait fetch: fetch_en at T, ack+rdata=A5C3 at T+1 -> IRwrite/pcwrite at T+2, inst=A5C3, pcplus=0001; pc=0001 at T+3.
//  3 Wait states: ack delayed 3 cycles -> imem_req=1, imem_addr=0001 stable all REQ cycles; IRwrite exactly once.
//  4 Redirect in REQ: redirect_pc=0040 during REQ at pc=0005 -> fetch completes (pcplus=0006), then pc=0040; next imem_addr=0040.
//  5 Wrap: redirect to FFFF, fetch -> pcplus=0000, pc=0000 after LOAD.
//  6 Reset mid-REQ then spurious ack in IDLE -> no IRwrite, inst=0000, pc=0000, busy=0.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads instruction memory over req/ack
// and hands the fetched word plus pc+inc to the IR/PC load stage.
module fetch_unit #(
  parameter int              PC_W     = 16,
  parameter int              INST_W   = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              PC_INC   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              imem_ack,
  output logic [PC_W-1:0]   pc,
  output logic [PC_W-1:0]   pcplus,
  output logic [INST_W-1:0] inst,
  output logic              IRwrite,
  output logic              pcwrite,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_LOAD = 2'd2
  } state_t;

  localparam logic [PC_W-1:0] LP_INC = PC_W'(PC_INC);

  state_t              r_state;
  state_t              w_state_next;
  logic [PC_W-1:0]     r_pc;
  logic [INST_W-1:0]   r_inst;
  logic                r_pend_valid;
  logic [PC_W-1:0]     r_pend_pc;
  logic [PC_W-1:0]     w_pcplus;
  logic                w_req;
  logic                w_load;

  assign w_pcplus = r_pc + LP_INC;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_req        = 1'b0;
    w_load       = 1'b0;
    case (r_state)
      S_IDLE: if (fetch_en) w_state_next = S_REQ;
      S_REQ: begin
        w_req = 1'b1;
        if (imem_ack) w_state_next = S_LOAD;
      end
      S_LOAD: begin
        w_load       = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // A live redirect in IDLE beats a pending one; redirects seen while busy are
  // parked and applied on the first IDLE cycle after the in-flight fetch retires.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc         <= RESET_PC;
      r_inst       <= '0;
      r_pend_valid <= 1'b0;
      r_pend_pc    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (redirect_valid)    r_pc <= redirect_pc;
          else if (r_pend_valid) r_pc <= r_pend_pc;
          r_pend_valid <= 1'b0;
        end
        S_REQ: begin
          if (imem_ack) r_inst <= imem_rdata;
          if (redirect_valid) begin
            r_pend_valid <= 1'b1;
            r_pend_pc    <= redirect_pc;
          end
        end
        S_LOAD: begin
          r_pc <= w_pcplus;
          if (redirect_valid) begin
            r_pend_valid <= 1'b1;
            r_pend_pc    <= redirect_pc;
          end
        end
        default: ;
      endcase
    end
  end

  // Strobes are masked while rst is high so a reset landing in LOAD never leaks a load.
  assign imem_req  = w_req;
  assign imem_addr = r_pc;
  assign pc        = r_pc;
  assign pcplus    = w_pcplus;
  assign inst      = r_inst;
  assign IRwrite   = w_load & ~rst;
  assign pcwrite   = w_load & ~rst;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit: reset, zero-wait and wait-state fetches,
// redirects, PC wrap, reset mid-request and back-to-back fetch cadence.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        fetch_en;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_ack;
  logic [15:0] pc;
  logic [15:0] pcplus;
  logic [15:0] inst;
  logic        IRwrite;
  logic        pcwrite;
  logic        busy;

  int n_checks;
  int n_fail;

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .imem_ack       (imem_ack),
    .pc             (pc),
    .pcplus         (pcplus),
    .inst           (inst),
    .IRwrite        (IRwrite),
    .pcwrite        (pcwrite),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; fetch_en = 1'b0; redirect_valid = 1'b0; redirect_pc = 16'h0;
    imem_ack = 1'b0; imem_rdata = 16'h0;
    tick(); tick();
    rst = 1'b0;
    n_checks++; if (pc !== 16'h0000) begin n_fail++; $display("FAIL reset_pc got %h want 0000", pc); end
    n_checks++; if (inst !== 16'h0000) begin n_fail++; $display("FAIL reset_inst got %h want 0000", inst); end
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b want 0", imem_req); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if ({IRwrite, pcwrite} !== 2'b00) begin n_fail++; $display("FAIL reset_strobes got %b want 00", {IRwrite, pcwrite}); end
    $display("test_reset: pc=%h inst=%h busy=%b", pc, inst, busy);
  endtask

  task automatic test_zero_wait();
    fetch_en = 1'b1;                         // cycle T
    tick();                                  // T+1: REQ
    fetch_en = 1'b0;
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin n_fail++; $display("FAIL zw_req got req=%b addr=%h want 1/0000", imem_req, imem_addr); end
    imem_ack = 1'b1; imem_rdata = 16'hA5C3;
    tick();                                  // T+2: LOAD
    imem_ack = 1'b0; imem_rdata = 16'h0;
    n_checks++; if ({IRwrite, pcwrite} !== 2'b11) begin n_fail++; $display("FAIL zw_strobes got %b want 11", {IRwrite, pcwrite}); end
    n_checks++; if (inst !== 16'hA5C3) begin n_fail++; $display("FAIL zw_inst got %h want a5c3", inst); end
    n_checks++; if (pcplus !== 16'h0001) begin n_fail++; $display("FAIL zw_pcplus got %h want 0001", pcplus); end
    tick();                                  // T+3: IDLE
    n_checks++; if (pc !== 16'h0001) begin n_fail++; $display("FAIL zw_pc got %h want 0001", pc); end
    n_checks++; if ({IRwrite, pcwrite, busy} !== 3'b000) begin n_fail++; $display("FAIL zw_idle got %b want 000", {IRwrite, pcwrite, busy}); end
    $display("test_zero_wait: inst=%h pc=%h", inst, pc);
  endtask

  task automatic test_wait_states();
    int ir_count;
    ir_count = 0;
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0001) begin n_fail++; $display("FAIL ws_req%0d got req=%b addr=%h want 1/0001", i, imem_req, imem_addr); end
      if (IRwrite === 1'b1) ir_count++;
      // ack outside REQ must not be confused with data: none here, just wait
      tick();
    end
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0001) begin n_fail++; $display("FAIL ws_req3 got req=%b addr=%h want 1/0001", imem_req, imem_addr); end
    imem_ack = 1'b1; imem_rdata = 16'h1234;
    tick();
    imem_ack = 1'b0;
    if (IRwrite === 1'b1) ir_count++;
    n_checks++; if (inst !== 16'h1234) begin n_fail++; $display("FAIL ws_inst got %h want 1234", inst); end
    tick();
    if (IRwrite === 1'b1) ir_count++;
    tick();
    if (IRwrite === 1'b1) ir_count++;
    n_checks++; if (ir_count != 1) begin n_fail++; $display("FAIL ws_irwrite_count got %0d want 1", ir_count); end
    n_checks++; if (pc !== 16'h0002) begin n_fail++; $display("FAIL ws_pc got %h want 0002", pc); end
    $display("test_wait_states: irwrite_count=%0d pc=%h", ir_count, pc);
  endtask

  task automatic test_redirect_in_req();
    // Same-cycle redirect and fetch in IDLE: fetch must use the new PC.
    redirect_valid = 1'b1; redirect_pc = 16'h0005; fetch_en = 1'b1;
    tick();
    redirect_valid = 1'b0; fetch_en = 1'b0;
    n_checks++; if (imem_addr !== 16'h0005) begin n_fail++; $display("FAIL rd_same_cycle got %h want 0005", imem_addr); end
    redirect_valid = 1'b1; redirect_pc = 16'h0040;
    tick();
    redirect_valid = 1'b0; redirect_pc = 16'h0;
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0005) begin n_fail++; $display("FAIL rd_hold got req=%b addr=%h want 1/0005", imem_req, imem_addr); end
    fetch_en = 1'b1;                         // ignored while busy
    imem_ack = 1'b1; imem_rdata = 16'hBEEF;
    tick();
    imem_ack = 1'b0; fetch_en = 1'b0;
    n_checks++; if (pcplus !== 16'h0006 || IRwrite !== 1'b1) begin n_fail++; $display("FAIL rd_load got pcplus=%h irw=%b want 0006/1", pcplus, IRwrite); end
    tick();
    n_checks++; if (pc !== 16'h0006 || busy !== 1'b0) begin n_fail++; $display("FAIL rd_after_load got pc=%h busy=%b want 0006/0", pc, busy); end
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0040) begin n_fail++; $display("FAIL rd_pending got req=%b addr=%h want 1/0040", imem_req, imem_addr); end
    imem_ack = 1'b1; imem_rdata = 16'h7777;
    tick();
    imem_ack = 1'b0;
    tick();
    n_checks++; if (pc !== 16'h0041) begin n_fail++; $display("FAIL rd_final_pc got %h want 0041", pc); end
    $display("test_redirect_in_req: pc=%h inst=%h", pc, inst);
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1; redirect_pc = 16'hFFFF; fetch_en = 1'b1;
    tick();
    redirect_valid = 1'b0; fetch_en = 1'b0;
    n_checks++; if (imem_addr !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_addr got %h want ffff", imem_addr); end
    imem_ack = 1'b1; imem_rdata = 16'h0F0F;
    tick();
    imem_ack = 1'b0;
    n_checks++; if (pcplus !== 16'h0000) begin n_fail++; $display("FAIL wrap_pcplus got %h want 0000", pcplus); end
    tick();
    n_checks++; if (pc !== 16'h0000) begin n_fail++; $display("FAIL wrap_pc got %h want 0000", pc); end
    $display("test_wrap: pc=%h inst=%h", pc, inst);
  endtask

  task automatic test_spurious_ack();
    // ack while IDLE must leave inst alone
    imem_ack = 1'b1; imem_rdata = 16'h5555;
    tick();
    imem_ack = 1'b0;
    n_checks++; if (inst !== 16'h0F0F || busy !== 1'b0) begin n_fail++; $display("FAIL idle_ack got inst=%h busy=%b want 0f0f/0", inst, busy); end
    $display("test_spurious_ack: inst=%h", inst);
  endtask

  task automatic test_reset_mid_req();
    redirect_valid = 1'b1; redirect_pc = 16'h0123; fetch_en = 1'b1;
    tick();
    redirect_valid = 1'b0; fetch_en = 1'b0;
    n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL rmr_req got %b want 1", imem_req); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++; if (imem_req !== 1'b0 || IRwrite !== 1'b0) begin n_fail++; $display("FAIL rmr_drop got req=%b irw=%b want 0/0", imem_req, IRwrite); end
    imem_ack = 1'b1; imem_rdata = 16'hDEAD;
    tick();
    imem_ack = 1'b0;
    n_checks++; if ({IRwrite, pcwrite, busy} !== 3'b000) begin n_fail++; $display("FAIL rmr_ctrl got %b want 000", {IRwrite, pcwrite, busy}); end
    n_checks++; if (inst !== 16'h0000 || pc !== 16'h0000) begin n_fail++; $display("FAIL rmr_state got inst=%h pc=%h want 0000/0000", inst, pc); end
    $display("test_reset_mid_req: pc=%h inst=%h", pc, inst);
  endtask

  task automatic test_reset_in_load();
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0; imem_ack = 1'b1; imem_rdata = 16'h4242;
    tick();                                  // LOAD
    imem_ack = 1'b0;
    rst = 1'b1;
    #1;
    n_checks++; if ({IRwrite, pcwrite} !== 2'b00) begin n_fail++; $display("FAIL ril_strobes got %b want 00", {IRwrite, pcwrite}); end
    tick();
    rst = 1'b0;
    n_checks++; if (pc !== 16'h0000 || inst !== 16'h0000) begin n_fail++; $display("FAIL ril_state got pc=%h inst=%h want 0000/0000", pc, inst); end
    $display("test_reset_in_load: pc=%h", pc);
  endtask

  task automatic test_back_to_back();
    int ir_cycles [$];
    int cyc;
    cyc = 0;
    fetch_en = 1'b1;                         // held high: refetch as soon as IDLE
    imem_ack = 1'b1;
    for (int i = 0; i < 9; i++) begin
      imem_rdata = 16'h1000 + 16'(i);
      tick();
      cyc++;
      if (IRwrite === 1'b1) ir_cycles.push_back(cyc);
    end
    fetch_en = 1'b0; imem_ack = 1'b0;
    tick(); tick();
    n_checks++; if (ir_cycles.size() != 3) begin n_fail++; $display("FAIL b2b_count got %0d want 3", ir_cycles.size()); end
    if (ir_cycles.size() == 3) begin
      n_checks++; if (ir_cycles[1] - ir_cycles[0] != 3 || ir_cycles[2] - ir_cycles[1] != 3) begin n_fail++; $display("FAIL b2b_period got %0d,%0d want 3,3", ir_cycles[1] - ir_cycles[0], ir_cycles[2] - ir_cycles[1]); end
    end
    n_checks++; if (pc !== 16'h0003) begin n_fail++; $display("FAIL b2b_pc got %h want 0003", pc); end
    $display("test_back_to_back: fetches=%0d pc=%h", ir_cycles.size(), pc);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_redirect_in_req();
    test_wrap();
    test_spurious_ack();
    test_reset_mid_req();
    test_reset_in_load();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
